// File: rtl/cuckoo_write_back_stage.sv
// cuckoo_write_back_stage
// Last stage of the cuckoo hash pipeline. It resolves a lookup, insert or
// delete against the per-table entries supplied by the upstream updater and
// issues at most one table write per cycle. A short history of the issued
// writes is fed back upstream so that in-flight reads can be corrected.
// When every table is full, an insert displaces a victim entry. The victim
// is chosen round-robin and offered on a valid/ready port for re-insertion.
// While that port is blocked, the stage stalls.
// Optional feature macro: EVICT_COUNT_EN adds a saturating 16-bit eviction
// counter on evict_count_o.
module cuckoo_write_back_stage #(
    parameter int DATA_WIDTH             = 4,
    parameter int KEY_WIDTH              = 2,
    parameter int NUMBER_OF_TABLES       = 3,
    parameter int HASH_ADR_WIDTH         = 2,
    parameter int FORWARDED_CLOCK_CYCLES = 2
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   clk_en,
    input  logic                                                   valid_i,
    input  logic [1:0]                                             op_i,
    input  logic [KEY_WIDTH-1:0]                                   key_i,
    input  logic [DATA_WIDTH-1:0]                                  data_i,
    input  logic [NUMBER_OF_TABLES*HASH_ADR_WIDTH-1:0]             hash_adr_i,
    input  logic [NUMBER_OF_TABLES*KEY_WIDTH-1:0]                  rd_key_i,
    input  logic [NUMBER_OF_TABLES*DATA_WIDTH-1:0]                 rd_data_i,
    input  logic [NUMBER_OF_TABLES-1:0]                            rd_valid_i,
    output logic                                                   stall_o,
    output logic [NUMBER_OF_TABLES-1:0]                            mem_we_o,
    output logic [HASH_ADR_WIDTH-1:0]                              mem_adr_o,
    output logic [KEY_WIDTH-1:0]                                   mem_key_o,
    output logic [DATA_WIDTH-1:0]                                  mem_data_o,
    output logic                                                   mem_valid_o,
    output logic [FORWARDED_CLOCK_CYCLES-1:0]                      fwd_valid_o,
    output logic [FORWARDED_CLOCK_CYCLES*$clog2(NUMBER_OF_TABLES)-1:0] fwd_table_o,
    output logic [FORWARDED_CLOCK_CYCLES*HASH_ADR_WIDTH-1:0]       fwd_hash_adr_o,
    output logic [FORWARDED_CLOCK_CYCLES*KEY_WIDTH-1:0]            fwd_key_o,
    output logic [FORWARDED_CLOCK_CYCLES*DATA_WIDTH-1:0]           fwd_data_o,
    output logic [FORWARDED_CLOCK_CYCLES-1:0]                      fwd_entry_valid_o,
    output logic                                                   result_valid_o,
    output logic                                                   result_hit_o,
    output logic [DATA_WIDTH-1:0]                                  result_data_o,
    output logic                                                   evict_valid_o,
    output logic [KEY_WIDTH-1:0]                                   evict_key_o,
    output logic [DATA_WIDTH-1:0]                                  evict_data_o,
`ifdef EVICT_COUNT_EN
    output logic [15:0]                                            evict_count_o,
`endif
    input  logic                                                   evict_ready_i
);

    localparam int N  = NUMBER_OF_TABLES;
    localparam int F  = FORWARDED_CLOCK_CYCLES;
    localparam int KW = KEY_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int AW = HASH_ADR_WIDTH;
    localparam int TW = $clog2(NUMBER_OF_TABLES);

    // Per-table decode results
    logic [N-1:0]  match_s;
    logic          hit_s;
    logic [TW-1:0] hit_idx_s;
    logic [KW-1:0] hit_key_s;
    logic [DW-1:0] hit_data_s;
    logic [AW-1:0] hit_adr_s;
    logic          empty_found_s;
    logic [TW-1:0] empty_idx_s;
    logic [AW-1:0] empty_adr_s;
    logic [KW-1:0] rr_key_s;
    logic [DW-1:0] rr_data_s;
    logic [AW-1:0] rr_adr_s;

    // Decision for the current request
    logic          wr_en_s;
    logic [TW-1:0] wr_tbl_s;
    logic [AW-1:0] wr_adr_s;
    logic [KW-1:0] wr_key_s;
    logic [DW-1:0] wr_data_s;
    logic          wr_valid_s;
    logic [N-1:0]  wr_we_s;
    logic          evict_s;
    logic          res_hit_s;
    logic [DW-1:0] res_data_s;
    logic          adv_s;

    // Registered state
    logic [N-1:0]    mem_we_r;
    logic [AW-1:0]   mem_adr_r;
    logic [KW-1:0]   mem_key_r;
    logic [DW-1:0]   mem_data_r;
    logic            mem_valid_r;
    logic [F-1:0]    fwd_valid_r;
    logic [F*TW-1:0] fwd_table_r;
    logic [F*AW-1:0] fwd_adr_r;
    logic [F*KW-1:0] fwd_key_r;
    logic [F*DW-1:0] fwd_data_r;
    logic [F-1:0]    fwd_ev_r;
    logic            res_valid_r;
    logic            res_hit_r;
    logic [DW-1:0]   res_data_r;
    logic            ev_valid_r;
    logic [KW-1:0]   ev_key_r;
    logic [DW-1:0]   ev_data_r;
    logic [TW-1:0]   rr_r;

    // The stage only advances when enabled and the eviction port is not blocking it
    assign stall_o = ev_valid_r & ~evict_ready_i;
    assign adv_s   = clk_en & ~stall_o;

    // Per-table match and empty scan; the descending loop leaves the lowest index selected
    always_comb begin
        match_s       = {N{1'b0}};
        hit_s         = 1'b0;
        hit_idx_s     = {TW{1'b0}};
        hit_key_s     = {KW{1'b0}};
        hit_data_s    = {DW{1'b0}};
        hit_adr_s     = {AW{1'b0}};
        empty_found_s = 1'b0;
        empty_idx_s   = {TW{1'b0}};
        empty_adr_s   = {AW{1'b0}};
        rr_key_s      = {KW{1'b0}};
        rr_data_s     = {DW{1'b0}};
        rr_adr_s      = {AW{1'b0}};
        for (int t = N - 1; t >= 0; t--) begin
            match_s[t] = rd_valid_i[t] & (rd_key_i[t*KW +: KW] == key_i);
            if (match_s[t]) begin
                hit_s      = 1'b1;
                hit_idx_s  = TW'(t);
                hit_key_s  = rd_key_i[t*KW +: KW];
                hit_data_s = rd_data_i[t*DW +: DW];
                hit_adr_s  = hash_adr_i[t*AW +: AW];
            end else begin
                hit_s = hit_s;
            end
            if (!rd_valid_i[t]) begin
                empty_found_s = 1'b1;
                empty_idx_s   = TW'(t);
                empty_adr_s   = hash_adr_i[t*AW +: AW];
            end else begin
                empty_found_s = empty_found_s;
            end
            if (rr_r == TW'(t)) begin
                rr_key_s  = rd_key_i[t*KW +: KW];
                rr_data_s = rd_data_i[t*DW +: DW];
                rr_adr_s  = hash_adr_i[t*AW +: AW];
            end else begin
                rr_key_s = rr_key_s;
            end
        end
    end

    // Operation decision: which table to write, what to write, and whether to evict
    always_comb begin
        wr_en_s    = 1'b0;
        wr_tbl_s   = {TW{1'b0}};
        wr_adr_s   = {AW{1'b0}};
        wr_key_s   = {KW{1'b0}};
        wr_data_s  = {DW{1'b0}};
        wr_valid_s = 1'b0;
        evict_s    = 1'b0;
        res_hit_s  = 1'b0;
        res_data_s = {DW{1'b0}};
        if (valid_i) begin
            case (op_i)
                2'b01: begin
                    wr_en_s    = 1'b1;
                    wr_key_s   = key_i;
                    wr_data_s  = data_i;
                    wr_valid_s = 1'b1;
                    if (hit_s) begin
                        wr_tbl_s  = hit_idx_s;
                        wr_adr_s  = hit_adr_s;
                        res_hit_s = 1'b1;
                    end else if (empty_found_s) begin
                        wr_tbl_s = empty_idx_s;
                        wr_adr_s = empty_adr_s;
                    end else begin
                        wr_tbl_s = rr_r;
                        wr_adr_s = rr_adr_s;
                        evict_s  = 1'b1;
                    end
                end
                2'b10: begin
                    if (hit_s) begin
                        wr_en_s    = 1'b1;
                        wr_tbl_s   = hit_idx_s;
                        wr_adr_s   = hit_adr_s;
                        wr_key_s   = hit_key_s;
                        wr_data_s  = hit_data_s;
                        wr_valid_s = 1'b0;
                        res_hit_s  = 1'b1;
                    end else begin
                        res_hit_s = 1'b0;
                    end
                end
                default: begin
                    res_hit_s  = hit_s;
                    res_data_s = hit_s ? hit_data_s : {DW{1'b0}};
                end
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
        wr_we_s = wr_en_s ? ({{(N-1){1'b0}}, 1'b1} << wr_tbl_s) : {N{1'b0}};
    end

    // Write port and result registers; the write enable drops in any non-advancing cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_r    <= {N{1'b0}};
            mem_adr_r   <= {AW{1'b0}};
            mem_key_r   <= {KW{1'b0}};
            mem_data_r  <= {DW{1'b0}};
            mem_valid_r <= 1'b0;
            res_valid_r <= 1'b0;
            res_hit_r   <= 1'b0;
            res_data_r  <= {DW{1'b0}};
        end else if (adv_s) begin
            mem_we_r    <= wr_we_s;
            mem_adr_r   <= wr_adr_s;
            mem_key_r   <= wr_key_s;
            mem_data_r  <= wr_data_s;
            mem_valid_r <= wr_valid_s;
            res_valid_r <= valid_i;
            res_hit_r   <= res_hit_s;
            res_data_r  <= res_data_s;
        end else begin
            mem_we_r <= {N{1'b0}};
        end
    end

    // Write history: shifts one slot per advance, newest write lands in slot 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_valid_r <= {F{1'b0}};
            fwd_table_r <= {(F*TW){1'b0}};
            fwd_adr_r   <= {(F*AW){1'b0}};
            fwd_key_r   <= {(F*KW){1'b0}};
            fwd_data_r  <= {(F*DW){1'b0}};
            fwd_ev_r    <= {F{1'b0}};
        end else if (adv_s) begin
            for (int k = F - 1; k >= 1; k--) begin
                fwd_valid_r[k]          <= fwd_valid_r[k-1];
                fwd_table_r[k*TW +: TW] <= fwd_table_r[(k-1)*TW +: TW];
                fwd_adr_r[k*AW +: AW]   <= fwd_adr_r[(k-1)*AW +: AW];
                fwd_key_r[k*KW +: KW]   <= fwd_key_r[(k-1)*KW +: KW];
                fwd_data_r[k*DW +: DW]  <= fwd_data_r[(k-1)*DW +: DW];
                fwd_ev_r[k]             <= fwd_ev_r[k-1];
            end
            fwd_valid_r[0]     <= wr_en_s;
            fwd_table_r[TW-1:0] <= wr_tbl_s;
            fwd_adr_r[AW-1:0]   <= wr_adr_s;
            fwd_key_r[KW-1:0]   <= wr_key_s;
            fwd_data_r[DW-1:0]  <= wr_data_s;
            fwd_ev_r[0]        <= wr_valid_s;
        end else begin
            fwd_valid_r <= fwd_valid_r;
        end
    end

    // Eviction holding register and round-robin victim pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_valid_r <= 1'b0;
            ev_key_r   <= {KW{1'b0}};
            ev_data_r  <= {DW{1'b0}};
            rr_r       <= {TW{1'b0}};
        end else if (adv_s && evict_s) begin
            ev_valid_r <= 1'b1;
            ev_key_r   <= rr_key_s;
            ev_data_r  <= rr_data_s;
            rr_r       <= (rr_r == TW'(N - 1)) ? {TW{1'b0}} : rr_r + TW'(1);
        end else if (ev_valid_r && evict_ready_i) begin
            ev_valid_r <= 1'b0;
        end else begin
            ev_valid_r <= ev_valid_r;
        end
    end

`ifdef EVICT_COUNT_EN
    logic [15:0] evict_count_r;

    // Saturating count of evictions issued
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evict_count_r <= 16'h0000;
        end else if (adv_s && evict_s && (evict_count_r != 16'hFFFF)) begin
            evict_count_r <= evict_count_r + 16'h0001;
        end else begin
            evict_count_r <= evict_count_r;
        end
    end

    assign evict_count_o = evict_count_r;
`endif

    assign mem_we_o          = mem_we_r;
    assign mem_adr_o         = mem_adr_r;
    assign mem_key_o         = mem_key_r;
    assign mem_data_o        = mem_data_r;
    assign mem_valid_o       = mem_valid_r;
    assign fwd_valid_o       = fwd_valid_r;
    assign fwd_table_o       = fwd_table_r;
    assign fwd_hash_adr_o    = fwd_adr_r;
    assign fwd_key_o         = fwd_key_r;
    assign fwd_data_o        = fwd_data_r;
    assign fwd_entry_valid_o = fwd_ev_r;
    assign result_valid_o    = res_valid_r;
    assign result_hit_o      = res_hit_r;
    assign result_data_o     = res_data_r;
    assign evict_valid_o     = ev_valid_r;
    assign evict_key_o       = ev_key_r;
    assign evict_data_o      = ev_data_r;

endmodule

// File: tb/tb_cuckoo_write_back_stage.sv
// Bench for cuckoo_write_back_stage: directed scenarios followed by random
// traffic, compared cycle by cycle against an integer reference model.
module tb_cuckoo_write_back_stage;

    localparam int DW = 4;
    localparam int KW = 2;
    localparam int N  = 3;
    localparam int AW = 2;
    localparam int F  = 2;
    localparam int TW = $clog2(N);

    logic            clk = 1'b0;
    logic            reset;
    logic            clk_en;
    logic            valid_i;
    logic [1:0]      op_i;
    logic [KW-1:0]   key_i;
    logic [DW-1:0]   data_i;
    logic [N*AW-1:0] hash_adr_i;
    logic [N*KW-1:0] rd_key_i;
    logic [N*DW-1:0] rd_data_i;
    logic [N-1:0]    rd_valid_i;
    logic            stall_o;
    logic [N-1:0]    mem_we_o;
    logic [AW-1:0]   mem_adr_o;
    logic [KW-1:0]   mem_key_o;
    logic [DW-1:0]   mem_data_o;
    logic            mem_valid_o;
    logic [F-1:0]    fwd_valid_o;
    logic [F*TW-1:0] fwd_table_o;
    logic [F*AW-1:0] fwd_hash_adr_o;
    logic [F*KW-1:0] fwd_key_o;
    logic [F*DW-1:0] fwd_data_o;
    logic [F-1:0]    fwd_entry_valid_o;
    logic            result_valid_o;
    logic            result_hit_o;
    logic [DW-1:0]   result_data_o;
    logic            evict_valid_o;
    logic [KW-1:0]   evict_key_o;
    logic [DW-1:0]   evict_data_o;
    logic            evict_ready_i;
`ifdef EVICT_COUNT_EN
    logic [15:0]     evict_count_o;
`endif

    cuckoo_write_back_stage #(
        .DATA_WIDTH(DW), .KEY_WIDTH(KW), .NUMBER_OF_TABLES(N),
        .HASH_ADR_WIDTH(AW), .FORWARDED_CLOCK_CYCLES(F)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .valid_i(valid_i),
        .op_i(op_i), .key_i(key_i), .data_i(data_i), .hash_adr_i(hash_adr_i),
        .rd_key_i(rd_key_i), .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i),
        .stall_o(stall_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
        .mem_key_o(mem_key_o), .mem_data_o(mem_data_o), .mem_valid_o(mem_valid_o),
        .fwd_valid_o(fwd_valid_o), .fwd_table_o(fwd_table_o),
        .fwd_hash_adr_o(fwd_hash_adr_o), .fwd_key_o(fwd_key_o),
        .fwd_data_o(fwd_data_o), .fwd_entry_valid_o(fwd_entry_valid_o),
        .result_valid_o(result_valid_o), .result_hit_o(result_hit_o),
        .result_data_o(result_data_o), .evict_valid_o(evict_valid_o),
        .evict_key_o(evict_key_o), .evict_data_o(evict_data_o),
`ifdef EVICT_COUNT_EN
        .evict_count_o(evict_count_o),
`endif
        .evict_ready_i(evict_ready_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    typedef struct {
        bit v;
        int tbl;
        int adr;
        int key;
        int data;
        bit ev;
    } hist_t;
    hist_t hist[$];
    int m_rr, m_we, m_adr, m_key, m_data, m_rd, m_ev_k, m_ev_d, m_cnt;
    bit m_mvalid, m_rv, m_rh, m_ev_v;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int fld(input logic [31:0] v, input int idx, input int w);
        return int'((v >> (idx * w)) & ((32'd1 << w) - 32'd1));
    endfunction

    task automatic model_reset();
        m_rr = 0; m_we = 0; m_adr = 0; m_key = 0; m_data = 0; m_rd = 0;
        m_ev_k = 0; m_ev_d = 0; m_cnt = 0;
        m_mvalid = 0; m_rv = 0; m_rh = 0; m_ev_v = 0;
        hist.delete();
        for (int k = 0; k < F; k++) hist.push_back('{0, 0, 0, 0, 0, 0});
    endtask

    // Applies the request rules to the inputs currently driven
    task automatic model_step();
        bit adv, hs, wr, wv;
        int fm, fe, tbl, wk, wd;
        adv = clk_en && !(m_ev_v && !evict_ready_i);
        hs  = m_ev_v && evict_ready_i;
        if (hs) m_ev_v = 0;
        if (!adv) begin
            m_we = 0;
            return;
        end
        wr = 0; wv = 0; tbl = 0; wk = 0; wd = 0;
        m_rv = valid_i; m_rh = 0; m_rd = 0;
        if (valid_i) begin
            fm = -1; fe = -1;
            for (int t = 0; t < N; t++) begin
                if (fm < 0 && rd_valid_i[t] && fld(rd_key_i, t, KW) == int'(key_i)) fm = t;
                if (fe < 0 && !rd_valid_i[t]) fe = t;
            end
            if (op_i == 2'b01) begin
                wr = 1; wv = 1; wk = key_i; wd = data_i;
                if (fm >= 0) begin
                    tbl = fm; m_rh = 1;
                end else if (fe >= 0) begin
                    tbl = fe;
                end else begin
                    tbl = m_rr;
                    m_ev_v = 1;
                    m_ev_k = fld(rd_key_i, m_rr, KW);
                    m_ev_d = fld(rd_data_i, m_rr, DW);
                    m_rr = (m_rr + 1) % N;
                    if (m_cnt < 65535) m_cnt++;
                end
            end else if (op_i == 2'b10) begin
                if (fm >= 0) begin
                    wr = 1; wv = 0; tbl = fm; m_rh = 1;
                    wk = fld(rd_key_i, fm, KW);
                    wd = fld(rd_data_i, fm, DW);
                end
            end else if (fm >= 0) begin
                m_rh = 1;
                m_rd = fld(rd_data_i, fm, DW);
            end
        end
        m_we     = wr ? (1 << tbl) : 0;
        m_adr    = wr ? fld(hash_adr_i, tbl, AW) : 0;
        m_key    = wr ? wk : 0;
        m_data   = wr ? wd : 0;
        m_mvalid = wr ? wv : 0;
        hist.push_front('{wr, wr ? tbl : 0, m_adr, m_key, m_data, m_mvalid});
        void'(hist.pop_back());
    endtask

    task automatic check_all();
        check_eq("mem_we", 32'(mem_we_o), m_we);
        check_eq("mem_adr", 32'(mem_adr_o), m_adr);
        check_eq("mem_key", 32'(mem_key_o), m_key);
        check_eq("mem_data", 32'(mem_data_o), m_data);
        check_eq("mem_valid", 32'(mem_valid_o), 32'(m_mvalid));
        check_eq("result_valid", 32'(result_valid_o), 32'(m_rv));
        check_eq("result_hit", 32'(result_hit_o), 32'(m_rh));
        check_eq("result_data", 32'(result_data_o), m_rd);
        check_eq("evict_valid", 32'(evict_valid_o), 32'(m_ev_v));
        if (m_ev_v) begin
            check_eq("evict_key", 32'(evict_key_o), m_ev_k);
            check_eq("evict_data", 32'(evict_data_o), m_ev_d);
        end
`ifdef EVICT_COUNT_EN
        check_eq("evict_count", 32'(evict_count_o), m_cnt);
`endif
        for (int k = 0; k < F; k++) begin
            check_eq($sformatf("fwd_valid[%0d]", k), 32'(fwd_valid_o[k]), 32'(hist[k].v));
            check_eq($sformatf("fwd_table[%0d]", k), fld(fwd_table_o, k, TW), hist[k].tbl);
            check_eq($sformatf("fwd_adr[%0d]", k), fld(fwd_hash_adr_o, k, AW), hist[k].adr);
            check_eq($sformatf("fwd_key[%0d]", k), fld(fwd_key_o, k, KW), hist[k].key);
            check_eq($sformatf("fwd_data[%0d]", k), fld(fwd_data_o, k, DW), hist[k].data);
            check_eq($sformatf("fwd_entry_valid[%0d]", k), 32'(fwd_entry_valid_o[k]), 32'(hist[k].ev));
        end
    endtask

    // Entered just after a falling edge with inputs already driven
    task automatic step();
        #1;
        check_eq("stall", 32'(stall_o), 32'(m_ev_v && !evict_ready_i));
        model_step();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic set_idle();
        clk_en = 1'b1; valid_i = 1'b0; op_i = 2'b00; key_i = '0; data_i = '0;
        hash_adr_i = '0; rd_key_i = '0; rd_data_i = '0; rd_valid_i = '0;
        evict_ready_i = 1'b0;
    endtask

    task automatic set_random();
        clk_en        = ($urandom_range(0, 9) != 0);
        valid_i       = ($urandom_range(0, 6) != 0);
        op_i          = 2'($urandom_range(0, 3));
        key_i         = KW'($urandom);
        data_i        = DW'($urandom);
        hash_adr_i    = (N*AW)'($urandom);
        rd_key_i      = (N*KW)'($urandom);
        rd_data_i     = (N*DW)'($urandom);
        for (int t = 0; t < N; t++) rd_valid_i[t] = ($urandom_range(0, 3) != 0);
        evict_ready_i = $urandom_range(0, 1) == 1;
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("stall_in_reset", 32'(stall_o), 32'd0);
        check_all();
        reset = 1'b1;

        // Idle cycles out of reset: everything stays zero
        repeat (4) step();

        // Insert key 2 data 5 into empty tables with addresses {1,3,0}
        valid_i = 1'b1; op_i = 2'b01; key_i = 2'd2; data_i = 4'd5;
        hash_adr_i = {2'd0, 2'd3, 2'd1};
        step();
        set_idle();
        step();

        // Lookup key 2 finding {2,9} in table 1
        valid_i = 1'b1; op_i = 2'b00; key_i = 2'd2;
        rd_valid_i = 3'b010; rd_key_i = {2'd0, 2'd2, 2'd0}; rd_data_i = {4'd0, 4'd9, 4'd0};
        step();

        // Delete key 3 present in tables 1 and 2: lower table wins
        valid_i = 1'b1; op_i = 2'b10; key_i = 2'd3; hash_adr_i = {2'd2, 2'd1, 2'd3};
        rd_valid_i = 3'b110; rd_key_i = {2'd3, 2'd3, 2'd0}; rd_data_i = {4'd7, 4'd6, 4'd1};
        step();

        // Delete an absent key
        key_i = 2'd1;
        step();

        // Insert with all tables full, victim held with ready low
        valid_i = 1'b1; op_i = 2'b01; key_i = 2'd1; data_i = 4'd12;
        rd_valid_i = 3'b111; rd_key_i = {2'd0, 2'd2, 2'd3}; rd_data_i = {4'd4, 4'd8, 4'd10};
        evict_ready_i = 1'b0;
        step();
        valid_i = 1'b1; op_i = 2'b00;
        repeat (3) step();
        evict_ready_i = 1'b1;
        valid_i = 1'b0;
        step();
        evict_ready_i = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_random();
            step();
        end

        // Create a pending eviction and reset while stalled
        set_idle();
        evict_ready_i = 1'b1;
        step();
        valid_i = 1'b1; op_i = 2'b01; key_i = 2'd0; data_i = 4'd3;
        rd_valid_i = 3'b111; rd_key_i = {2'd1, 2'd2, 2'd3}; rd_data_i = {4'd5, 4'd6, 4'd7};
        evict_ready_i = 1'b0;
        step();
        valid_i = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        check_eq("evict_valid_async_reset", 32'(evict_valid_o), 32'd0);
        check_eq("stall_async_reset", 32'(stall_o), 32'd0);
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 100; i++) begin
            set_random();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cuckoo_write_back_stage.md
Name: cuckoo_write_back_stage

Overview:
- Final stage of the cuckoo hash pipeline; sits directly downstream of forward_position_updater and consumes its corrected per-table entries.
- Decides lookup hit, insert slot, delete, or eviction, and issues one table write per cycle.
- Keeps a FORWARDED_CLOCK_CYCLES-deep history of issued writes; this history drives the forward_* inputs of the upstream updater.
- Hands evicted entries out on a valid/ready port for re-insertion.

Parameters:
- DATA_WIDTH, 4, payload width.
- KEY_WIDTH, 2, key width.
- NUMBER_OF_TABLES, 3, number of cuckoo tables (N), at least 2.
- HASH_ADR_WIDTH, 2, per-table address width.
- FORWARDED_CLOCK_CYCLES, 2, write-history depth (F), at least 1.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- clk_en  in  1  stage advance enable.
- valid_i  in  1  request valid.
- op_i  in  2  00 lookup, 01 insert, 10 delete, 11 treated as lookup.
- key_i  in  KEY_WIDTH  request key.
- data_i  in  DATA_WIDTH  request data.
- hash_adr_i  in  [N] x HASH_ADR_WIDTH  per-table address of the request.
- rd_key_i  in  [N] x KEY_WIDTH  corrected stored key per table.
- rd_data_i  in  [N] x DATA_WIDTH  corrected stored data per table.
- rd_valid_i  in  N  corrected occupied flag per table.
- stall_o  out  1  upstream must hold its stage.
- mem_we_o  out  N  one-hot table write enable, or all zero.
- mem_adr_o  out  HASH_ADR_WIDTH  write address.
- mem_key_o  out  KEY_WIDTH  write key.
- mem_data_o  out  DATA_WIDTH  write data.
- mem_valid_o  out  1  written occupied flag.
- fwd_valid_o  out  F  history slot holds a write.
- fwd_table_o  out  [F] x clog2(N)  table index of each write.
- fwd_hash_adr_o  out  [F] x HASH_ADR_WIDTH  address of each write.
- fwd_key_o  out  [F] x KEY_WIDTH  key of each write.
- fwd_data_o  out  [F] x DATA_WIDTH  data of each write.
- fwd_entry_valid_o  out  F  occupied flag of each write.
- result_valid_o  out  1  request completed.
- result_hit_o  out  1  key was found.
- result_data_o  out  DATA_WIDTH  stored data on a lookup hit, else 0.
- evict_valid_o  out  1  evicted entry available.
- evict_key_o  out  KEY_WIDTH  evicted key.
- evict_data_o  out  DATA_WIDTH  evicted data.
- evict_ready_i  in  1  consumer accepts the evicted entry.

Behaviour:
- Reset (async, active-low): all outputs 0, history cleared, round-robin pointer rr = 0.
- Advance condition: adv = clk_en & ~stall_o. All registered outputs update only when adv; otherwise they hold.
- Exception: mem_we_o is forced to 0 in any cycle without adv.
- stall_o = evict_valid_o & ~evict_ready_i (combinational).
- Latency: request sampled on an adv edge; mem_*, result_* and fwd slot 0 are valid after that edge (1 cycle).
- Match: match[t] = rd_valid_i[t] & (rd_key_i[t] == key_i). The lowest matching index wins.
- Lookup: no write. result_hit_o = any match; result_data_o = matched data.
- Insert with match: overwrite data in the matching table, mem_valid_o = 1, hit = 1.
- Insert, no match, some table empty: write to the lowest-index empty table, hit = 0.
- Insert, no match, all tables full: write to table rr and evict that table's old entry (evict_valid_o = 1). Then rr = (rr+1) mod N, wrapping N-1 to 0.
- Delete with match: write mem_valid_o = 0, key/data unchanged, hit = 1.
- Delete miss: no write, hit = 0.
- valid_i = 0 at adv: no write, result_valid_o = 0, history shifts in an empty slot.
- History: on adv, slot k takes slot k-1 (k = 1..F-1) and slot 0 takes the write just issued. fwd_valid_o[0] = 0 if no write was issued. The history is frozen while adv = 0.
- Eviction handshake: evict_* is held until evict_valid_o & evict_ready_i. On that handshake, evict_valid_o clears on the same edge, and the stage may advance in that cycle (stall_o = 0).
- If a new eviction coincides with an accepted eviction, the new entry replaces it and evict_valid_o stays 1.
- Reset mid-stall drops the pending eviction.

Optional Feature:
- Macro: EVICT_COUNT_EN.
- When defined: adds output evict_count_o, 16 bits, reset 0. It increments on each eviction issued and saturates at 0xFFFF.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset with clk_en=1, valid_i=0 -> all outputs 0; fwd_valid_o=00 for 4 cycles.
- Insert key 2, data 5; all tables empty; adr {1,3,0} -> next cycle mem_we_o=001, mem_adr_o=1, fwd slot 0 = {table 0, adr 1, key 2, data 5}; one cycle later it appears in slot 1.
- Lookup key 2 with rd entry table 1 = {2,9,valid} -> result_hit_o=1, result_data_o=9, mem_we_o=000.
- Insert key 1 with all tables full, rr=0 -> mem_we_o=001 and evict_valid_o=1 with table 0's old key/data. Hold evict_ready_i=0 for 3 cycles -> stall_o=1, mem_we_o=000, history frozen. Raise ready -> eviction clears and rr=1.
- Delete key 3 matching tables 1 and 2 -> mem_we_o=010, mem_valid_o=0, result_hit_o=1.
- Delete of an absent key -> no write, result_hit_o=0.
- Assert reset during a pending eviction -> evict_valid_o=0 and stall_o=0 immediately (asynchronous).
